regfile_scoreboard: RTL and testbench

Architectural register file and pending-write scoreboard for the decode/issue boundary. It consumes `reg_id_t` operand and destination IDs produced by decode and returns 64-bit operand values. It gates issue while any source has an outstanding write, and retires pending writes on writeback. It holds the `REG_FILE_SIZE` real registers, indexed through `reg_num()`. Fake IDs (`rnil`, `rip`, `rimm`) are resolved here and never stored.

---
 rtl/regfile_scoreboard_pkg.sv | 36 +++
 rtl/regfile_scoreboard_sb_counter.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Register ID space shared by decode and the register file, plus scoreboard sizing.
// Fake IDs (rnil, rip, rimm) sit below rax; everything from rax up is architectural.
package regfile_scoreboard_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W  = 2;

  typedef enum logic [7:0] {
    rnil = 8'd0, rip, rimm,
    rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
    r8, r9, r10, r11, r12, r13, r14, r15,
    rflags
  } reg_id_t;

  localparam int REG_FILE_SIZE = int'(rflags) - int'(rax) + 1;

  typedef logic [DEF_CNT_W-1:0] pend_cnt_t;

  function automatic logic is_real_reg(reg_id_t id);
    return id >= rax;
  endfunction

  function automatic logic [7:0] reg_num(reg_id_t id);
    return 8'(id) - 8'(rax);
  endfunction

  // Real IDs beyond the last register match no entry.
  function automatic logic id_hits(reg_id_t id, int idx);
    return is_real_reg(id) && (reg_num(id) == 8'(idx));
  endfunction

  function automatic logic in_file(reg_id_t id);
    return is_real_reg(id) && (reg_num(id) < 8'(REG_FILE_SIZE));
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One pending-write counter: net +inc/-dec per edge, clamped at 0 on underflow.
// inc_i is the requested increment; it is only applied when inc_en_i (issue fire) is high.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] inc_i,
  input  logic       inc_en_i,
  input  logic [1:0] dec_i,
  output logic       busy_o,
  output logic       drains_o,
  output logic       would_ovf_o,
  output logic       underflow_o
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAX_CNT = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic [SW-1:0]    up_req, up_act, dec_ext;

  always_comb begin
    dec_ext     = SW'(dec_i);
    up_req      = SW'(pend_q) + SW'(inc_i);
    up_act      = SW'(pend_q) + (inc_en_i ? SW'(inc_i) : '0);
    busy_o      = (pend_q != '0);
    // Same-cycle writebacks retire every outstanding write: the source value is on the bypass.
    drains_o    = (SW'(pend_q) <= dec_ext);
    would_ovf_o = (up_req >= dec_ext) && ((up_req - dec_ext) > MAX_CNT);
    underflow_o = (up_act < dec_ext);
    pend_d      = underflow_o ? '0 : CNT_W'(up_act - dec_ext);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pend_q <= '0;
    else         pend_q <= pend_d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and a per-register
// pending-write scoreboard that gates issue until sources are retired.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  reg_id_t           src_id [2],
  output logic [DATA_W-1:0] rd_data [2],
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              iss_valid,
  input  reg_id_t           iss_dst [2],
  output logic              iss_ready,
  input  logic [1:0]        wb_valid,
  input  reg_id_t           wb_id [2],
  input  logic [DATA_W-1:0] wb_data [2],
  output logic              sb_err
);

  localparam int RFLAGS_IDX = int'(rflags) - int'(rax);

  logic [DATA_W-1:0]        regs_q [REG_FILE_SIZE];
  logic                     sb_err_q, sb_err_d;
  logic                     fire;
  logic [1:0]               inc_req [REG_FILE_SIZE];
  logic [1:0]               dec     [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] wb_hit0, wb_hit1, src_hit;
  logic [REG_FILE_SIZE-1:0] busy, drains, would_ovf, underflow;

  for (genvar i = 0; i < REG_FILE_SIZE; i++) begin : g_reg
    logic d0, d1;
    assign d0         = id_hits(iss_dst[0], i);
    assign d1         = id_hits(iss_dst[1], i);
    assign wb_hit0[i] = wb_valid[0] && id_hits(wb_id[0], i);
    assign wb_hit1[i] = wb_valid[1] && id_hits(wb_id[1], i);
    assign src_hit[i] = id_hits(src_id[0], i) || id_hits(src_id[1], i);
    assign inc_req[i] = {1'b0, d0} + {1'b0, d1};
    assign dec[i]     = {1'b0, wb_hit0[i]} + {1'b0, wb_hit1[i]};

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i       (clk),
      .reset_i     (reset),
      .inc_i       (inc_req[i]),
      .inc_en_i    (fire),
      .dec_i       (dec[i]),
      .busy_o      (busy[i]),
      .drains_o    (drains[i]),
      .would_ovf_o (would_ovf[i]),
      .underflow_o (underflow[i])
    );
  end

  // Readiness never looks at iss_valid, so fire -> counter -> ready has no loop.
  assign iss_ready = ~|(src_hit & busy & ~drains) & ~|would_ovf;
  assign fire      = iss_valid && iss_ready;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_data[k] = '0;
      case (src_id[k])
        rnil:    rd_data[k] = '0;
        rip:     rd_data[k] = pc_in;
        rimm:    rd_data[k] = imm_in;
        default: begin
          for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (id_hits(src_id[k], i)) rd_data[k] = regs_q[i];
          end
          if (in_file(src_id[k])) begin
            if (wb_valid[0] && (wb_id[0] == src_id[k])) rd_data[k] = wb_data[0];
            if (wb_valid[1] && (wb_id[1] == src_id[k])) rd_data[k] = wb_data[1];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_FILE_SIZE; i++)
        regs_q[i] <= (i == RFLAGS_IDX) ? DATA_W'(2) : '0;
    end else begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        if (wb_hit1[i])      regs_q[i] <= wb_data[1];
        else if (wb_hit0[i]) regs_q[i] <= wb_data[0];
      end
    end
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (|underflow) sb_err_d = 1'b1;
    if (wb_valid[0] && !is_real_reg(wb_id[0])) sb_err_d = 1'b1;
    if (wb_valid[1] && !is_real_reg(wb_id[1])) sb_err_d = 1'b1;
    if (fire && ((iss_dst[0] inside {rip, rimm}) || (iss_dst[1] inside {rip, rimm})))
      sb_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations plus
// randomized traffic, all checked against an array-based model of the register file.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  localparam int NREG = 17;

  logic        clk, reset;
  reg_id_t     src_id [2];
  logic [63:0] rd_data [2];
  logic [63:0] pc_in, imm_in;
  logic        iss_valid;
  reg_id_t     iss_dst [2];
  logic        iss_ready;
  logic [1:0]  wb_valid;
  reg_id_t     wb_id [2];
  logic [63:0] wb_data [2];
  logic        sb_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] m_regs [NREG];
  int          m_pend [NREG];
  bit          m_err;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .src_id(src_id), .rd_data(rd_data),
    .pc_in(pc_in), .imm_in(imm_in),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .sb_err(sb_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic int idx(reg_id_t id);
    if (int'(id) >= 3 && int'(id) <= 19) return int'(id) - 3;
    return -1;
  endfunction

  function automatic int wb_count(int n);
    int c = 0;
    for (int k = 0; k < 2; k++) if (wb_valid[k] && idx(wb_id[k]) == n) c++;
    return c;
  endfunction

  function automatic int dst_count(int n);
    int c = 0;
    for (int k = 0; k < 2; k++) if (idx(iss_dst[k]) == n) c++;
    return c;
  endfunction

  function automatic logic [63:0] exp_rd(reg_id_t id);
    logic [63:0] v;
    int n;
    if (id == rnil) return 64'd0;
    if (id == rip)  return pc_in;
    if (id == rimm) return imm_in;
    n = idx(id);
    v = m_regs[n];
    if (wb_valid[0] && wb_id[0] == id) v = wb_data[0];
    if (wb_valid[1] && wb_id[1] == id) v = wb_data[1];
    return v;
  endfunction

  function automatic bit exp_ready();
    int n;
    for (int k = 0; k < 2; k++) begin
      n = idx(src_id[k]);
      if (n >= 0 && m_pend[n] > 0 && m_pend[n] - wb_count(n) > 0) return 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      n = idx(iss_dst[k]);
      if (n >= 0 && m_pend[n] + dst_count(n) - wb_count(n) > 3) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < NREG; n++) begin
      m_regs[n] = 64'd0;
      m_pend[n] = 0;
    end
    m_regs[16] = 64'h2;
    m_err = 1'b0;
  endfunction

  function automatic void model_edge();
    bit fire;
    int v, n;
    fire = iss_valid && exp_ready();
    for (n = 0; n < NREG; n++) begin
      v = m_pend[n] + (fire ? dst_count(n) : 0) - wb_count(n);
      if (v < 0) begin v = 0; m_err = 1'b1; end
      m_pend[n] = v;
    end
    for (int k = 0; k < 2; k++) begin
      if (wb_valid[k]) begin
        n = idx(wb_id[k]);
        if (n >= 0) m_regs[n] = wb_data[k];
        else m_err = 1'b1;
      end
      if (fire && (iss_dst[k] == rip || iss_dst[k] == rimm)) m_err = 1'b1;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model rd_data0", rd_data[0], exp_rd(src_id[0]));
    chk("model rd_data1", rd_data[1], exp_rd(src_id[1]));
    chk("model iss_ready", 64'(iss_ready), 64'(exp_ready()));
    chk("model sb_err", 64'(sb_err), 64'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    src_id[0] = rnil;  src_id[1] = rnil;
    iss_dst[0] = rnil; iss_dst[1] = rnil;
    wb_id[0] = rnil;   wb_id[1] = rnil;
    wb_data[0] = '0;   wb_data[1] = '0;
    iss_valid = 1'b0;  wb_valid = 2'b00;
    pc_in = '0;        imm_in = '0;
  endtask

  // Called at a negedge with inputs settled: compare, advance the model on the edge.
  task automatic tick();
    check_model();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic reg_id_t pick_real();
    reg_id_t pool [7];
    pool = '{rax, rcx, rdx, rbx, r9, rflags, r15};
    return pool[$urandom_range(0, 6)];
  endfunction

  function automatic reg_id_t pick_src();
    int r = $urandom_range(0, 9);
    if (r == 0) return rnil;
    if (r == 1) return rip;
    if (r == 2) return rimm;
    return pick_real();
  endfunction

  function automatic reg_id_t pick_dst();
    int r = $urandom_range(0, 99);
    if (r < 25) return rnil;
    if (r == 25) return rip;
    if (r == 26) return rimm;
    return pick_real();
  endfunction

  function automatic reg_id_t pick_wb();
    int s, n;
    int r = $urandom_range(0, 99);
    if (r == 0) return rip;
    if (r < 6) return pick_real();
    s = $urandom_range(0, NREG - 1);
    for (int j = 0; j < NREG; j++) begin
      n = (s + j) % NREG;
      if (m_pend[n] > 0) return reg_id_t'(8'(n + 3));
    end
    return pick_real();
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // reset defaults
    src_id[0] = rflags; src_id[1] = rax;
    iss_dst[0] = rbx;   iss_dst[1] = r9;
    #1;
    chk("reset rflags", rd_data[0], 64'h2);
    chk("reset rax", rd_data[1], 64'h0);
    chk("reset ready", 64'(iss_ready), 64'h1);
    chk("reset sb_err", 64'(sb_err), 64'h0);
    tick();

    // fake IDs
    set_idle();
    src_id[0] = rip; src_id[1] = rnil; pc_in = 64'h400000; imm_in = 64'd5;
    #1;
    chk("rip read", rd_data[0], 64'h400000);
    chk("rnil read", rd_data[1], 64'h0);
    src_id[1] = rimm;
    #1;
    chk("rimm read", rd_data[1], 64'd5);
    tick();

    // busy stall and bypass
    set_idle();
    iss_valid = 1'b1; iss_dst[0] = rcx;
    #1;
    tick();
    set_idle();
    src_id[0] = rcx; iss_valid = 1'b1;
    #1;
    chk("busy stall", 64'(iss_ready), 64'h0);
    wb_valid = 2'b01; wb_id[0] = rcx; wb_data[0] = 64'hDEAD;
    #1;
    chk("retire unstall", 64'(iss_ready), 64'h1);
    chk("bypass data", rd_data[0], 64'hDEAD);
    iss_valid = 1'b0;
    tick();

    // dual writeback to one register
    set_idle();
    iss_valid = 1'b1; iss_dst[0] = rbx; iss_dst[1] = rbx;
    #1;
    tick();
    set_idle();
    wb_valid = 2'b11; wb_id[0] = rbx; wb_id[1] = rbx;
    wb_data[0] = 64'd1; wb_data[1] = 64'd2;
    #1;
    chk("dual wb bypass", exp_rd(rbx), 64'd2);
    tick();
    set_idle();
    src_id[0] = rbx;
    #1;
    chk("dual wb stored", rd_data[0], 64'd2);
    chk("dual wb drained", 64'(iss_ready), 64'h1);
    chk("dual wb no err", 64'(sb_err), 64'h0);
    tick();

    // saturation at 3 outstanding writes
    for (int j = 0; j < 3; j++) begin
      set_idle();
      iss_valid = 1'b1; iss_dst[0] = r9;
      #1;
      tick();
    end
    set_idle();
    iss_valid = 1'b1; iss_dst[0] = r9;
    #1;
    chk("sat stall", 64'(iss_ready), 64'h0);
    wb_valid = 2'b01; wb_id[0] = r9; wb_data[0] = 64'h99;
    #1;
    chk("sat issue+wb", 64'(iss_ready), 64'h1);
    tick();
    set_idle();
    iss_dst[0] = r9;
    #1;
    chk("sat still full", 64'(iss_ready), 64'h0);
    for (int j = 0; j < 3; j++) begin
      set_idle();
      wb_valid = 2'b01; wb_id[0] = r9; wb_data[0] = 64'(j);
      #1;
      tick();
    end

    // underflow sets the error but still writes
    set_idle();
    wb_valid = 2'b01; wb_id[0] = r12; wb_data[0] = 64'h1234;
    #1;
    chk("pre-underflow err", 64'(sb_err), 64'h0);
    tick();
    set_idle();
    src_id[0] = r12;
    #1;
    chk("underflow err", 64'(sb_err), 64'h1);
    chk("underflow write", rd_data[0], 64'h1234);
    tick();

    // asynchronous reset mid-cycle
    set_idle();
    iss_valid = 1'b1; iss_dst[0] = rcx;
    #1;
    tick();
    set_idle();
    src_id[0] = rcx; src_id[1] = rflags;
    #1;
    chk("pre-reset stall", 64'(iss_ready), 64'h0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async err clear", 64'(sb_err), 64'h0);
    chk("async ready", 64'(iss_ready), 64'h1);
    chk("async rcx clear", rd_data[0], 64'h0);
    chk("async rflags", rd_data[1], 64'h2);
    #1;
    reset = 1'b0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) begin
        set_idle();
        do_reset();
      end
      src_id[0]  = pick_src();
      src_id[1]  = pick_src();
      iss_dst[0] = pick_dst();
      iss_dst[1] = pick_dst();
      iss_valid  = ($urandom_range(0, 1) == 1);
      wb_valid[0] = ($urandom_range(0, 9) < 4);
      wb_valid[1] = ($urandom_range(0, 9) < 3);
      wb_id[0] = pick_wb();
      wb_id[1] = pick_wb();
      wb_data[0] = {$urandom, $urandom};
      wb_data[1] = {$urandom, $urandom};
      pc_in  = {$urandom, $urandom};
      imm_in = {$urandom, $urandom};
      #1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
